arb_req_agent: RTL and testbench
================================

ARB_REQ_AGENT -- requirements
Module: arb_req_agent

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, defining the payload symbol width.
REQ-002 The block SHALL have parameter DEPTH, default 4, defining the FIFO entry count (power of two, >=2).
REQ-003 The block SHALL have parameter TIMEOUT, default 64, defining the maximum grant-wait cycles (used only with ARB_REQ_TIMEOUT_EN).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the clock.
REQ-006 The block SHALL have port rst_i, input, 1 bit: the asynchronous active-high reset.
REQ-007 The block SHALL have port in_valid_i, input, 1 bit: the upstream word is valid.
REQ-008 The block SHALL have port in_ready_o, output, 1 bit: the FIFO can accept a word.
REQ-009 The block SHALL have port in_data_i, input, DATA_W bits: the upstream payload.
REQ-010 The block SHALL have port in_last_i, input, 1 bit: the word ends a packet.
REQ-011 The block SHALL have port req_o, output, 1 bit: the request to the arbiter.
REQ-012 The block SHALL have port gnt_i, input, 1 bit: this agent's grant bit from the arbiter.
REQ-013 The block SHALL have port out_valid_o, output, 1 bit: a downstream word is valid.
REQ-014 The block SHALL have port out_ready_i, input, 1 bit: downstream accepts the word.
REQ-015 The block SHALL have port out_data_o, output, DATA_W bits: the downstream payload.
REQ-016 The block SHALL have port out_last_o, output, 1 bit: the downstream word ends a packet.
REQ-017 The block SHALL have port timeout_o, output, 1 bit: a one-cycle pulse on grant-wait timeout.

Function
REQ-018 The FIFO SHALL store {last, data}; push on in_valid_i&&in_ready_o; in_ready_o = !full.
REQ-019 pkt_cnt SHALL increment on a push with last and decrement on a pop with last; simultaneous increment and decrement SHALL leave it unchanged.
REQ-020 The FSM SHALL have states IDLE, REQ, XFER and REL, encoded in registers; req_o SHALL be 1 exactly in REQ and XFER.
REQ-021 IDLE->REQ SHALL occur when pkt_cnt>0 or (full && pkt_cnt==0) (cut-through for packets larger than DEPTH).
REQ-022 REQ->XFER SHALL occur on a clock edge with gnt_i=1; without a grant the FSM SHALL stay in REQ.
REQ-023 In XFER: out_valid_o = !empty; out_data_o and out_last_o SHALL be driven combinationally from the FIFO head; pop on out_valid_o&&out_ready_i.
REQ-024 XFER->REL SHALL occur on popping a word with last=1; REL->IDLE SHALL occur unconditionally after one cycle (req_o=0 for exactly one cycle between packets).
REQ-025 gnt_i deasserting during XFER SHALL be ignored; the packet SHALL complete.
REQ-026 Latency: req_o SHALL rise at the second rising edge after the last-word push edge.
REQ-027 The first out_valid_o SHALL occur in the cycle after the gnt_i-sampling edge.
REQ-028 Pushes SHALL continue during every state, including same-cycle push and pop while full.
REQ-029 out_valid_o SHALL be 0 outside XFER.

Reset
REQ-030 While rst_i=1: state SHALL be IDLE and FIFO pointers and pkt_cnt SHALL be 0.
REQ-031 While rst_i=1: req_o, out_valid_o and timeout_o SHALL be 0, and in_ready_o SHALL be 1.
REQ-032 Reset asserted mid-packet SHALL discard all buffered words.

Configuration
REQ-033 With macro ARB_REQ_TIMEOUT_EN defined, a counter SHALL clear on entering REQ and count each cycle spent in REQ.
REQ-034 With ARB_REQ_TIMEOUT_EN defined, on reaching TIMEOUT the FSM SHALL pulse timeout_o for one cycle and go REQ->REL (dropping req_o for one cycle), then re-request via IDLE; the FIFO SHALL be untouched.
REQ-035 Without ARB_REQ_TIMEOUT_EN, no counter SHALL exist and timeout_o SHALL be tied to 0.

Verification
REQ-036 Push 3 words (0x11, 0x22, 0x33 with last) -> req_o rises 2 edges after the last push; gnt_i=1 -> 0x11, 0x22, 0x33 out on 3 consecutive cycles, out_last_o only on 0x33, then req_o=0 for 1 cycle.
REQ-037 Two 2-word packets buffered, gnt_i held 1 -> packet 1 completes, req_o low one cycle, then re-raised for packet 2.
REQ-038 Push 4 words with no last (DEPTH=4) -> in_ready_o=0 and cut-through request; after grant, pops free space and the 6-word packet streams out intact.
REQ-039 out_ready_i toggling 1/0 during XFER, gnt_i dropped mid-packet -> no word lost or duplicated; order preserved.
REQ-040 ARB_REQ_TIMEOUT_EN, TIMEOUT=8, gnt_i=0 -> timeout_o pulses after 8 REQ cycles, req_o=0 one cycle, then req_o=1 again; without the macro, timeout_o stays 0.
REQ-041 rst_i asserted mid-XFER -> outputs 0 immediately, in_ready_o=1; post-reset, no stale words are emitted.

Source files
------------

// File: rtl/arb_req_agent.sv
// arb_req_agent: buffers upstream packet words in a small FIFO, requests the
// shared arbiter once a whole packet (or a FIFO-full cut-through chunk) is
// waiting, and streams the packet downstream after the grant.
// Optional grant-wait timeout: define ARB_REQ_TIMEOUT_EN.
module arb_req_agent #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              req_o,
    input  logic              gnt_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              timeout_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DATA_W:0] mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W:0] head;
    logic            head_last;
    logic            full, empty, push, pop;
    logic            tmo_hit;

    // FIFO status; pointers carry one wrap bit to tell full from empty
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready_o = !full;
    assign push       = in_valid_i && !full;

    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign head_last   = head[DATA_W];
    assign out_data_o  = head[DATA_W-1:0];
    assign out_last_o  = head_last;
    assign out_valid_o = (state_q == XFER) && !empty;
    assign pop         = out_valid_o && out_ready_i;
    assign req_o       = (state_q == REQ) || (state_q == XFER);

    // FIFO storage write port; contents need no reset since pointers gate reads
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_last_i, in_data_i};
        end
    end

    // next pointers and complete-packet count
    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + ONE : rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if ((push && in_last_i) && !(pop && head_last)) begin
            pkt_cnt_d = pkt_cnt_q + ONE;
        end else if (!(push && in_last_i) && (pop && head_last)) begin
            pkt_cnt_d = pkt_cnt_q - ONE;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q;

    assign tmo_hit   = (state_q == REQ) && !gnt_i && (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign timeout_o = timeout_q;

    // counts cycles spent in REQ; held at zero elsewhere so each entry starts fresh
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == REQ) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    // timeout counter and one-cycle pulse register (pulse lines up with REL)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= tmo_hit;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // request FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if ((pkt_cnt_q != '0) || (full && (pkt_cnt_q == '0))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (gnt_i) begin
                    state_d = XFER;
                end else if (tmo_hit) begin
                    state_d = REL;
                end
            end
            XFER: begin
                if (pop && head_last) begin
                    state_d = REL;
                end
            end
            REL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state, pointer and packet-count registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_arb_req_agent.sv
// tb_arb_req_agent: cycle table for the basic packet flow, then hand-written
// sequences; every accepted input word is queued and checked when it pops.
module tb_arb_req_agent;

    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          in_last_i;
    logic          req_o;
    logic          gnt_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          out_last_o;
    logic          timeout_o;

    always #5 clk_i = ~clk_i;

    arb_req_agent #(
        .DATA_W (DW),
        .DEPTH  (4),
        .TIMEOUT(TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .in_last_i  (in_last_i),
        .req_o      (req_o),
        .gnt_i      (gnt_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o),
        .timeout_o  (timeout_o)
    );

    typedef struct {
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic          in_last;
        logic          gnt;
        logic          out_ready;
        logic          exp_req;
        logic          exp_in_ready;
        logic          exp_out_valid;
        logic          exp_out_last;
    } vec_t;

    vec_t          vecs [10];
    logic [DW:0]   sb [$];
    int            checks   = 0;
    int            failures = 0;
    int            pops     = 0;
    logic          pushed;
    logic          popped_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // sampled mid-cycle: score pops against the queue, record accepted pushes
    task automatic monitor();
        logic [DW:0] exp_word;
        pushed      = 1'b0;
        popped_last = 1'b0;
        if (!rst_i) begin
            if (out_valid_o && out_ready_i) begin
                pops++;
                popped_last = out_last_o;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: got 0x%0h, expected no word", {out_last_o, out_data_o});
                end else begin
                    exp_word = sb.pop_front();
                    chk("pop_word", 32'({out_last_o, out_data_o}), 32'(exp_word));
                end
                chk("valid_implies_req", 32'(req_o), 32'd1);
            end
            if (in_valid_i && in_ready_o) begin
                sb.push_back({in_last_i, in_data_i});
                pushed = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic l);
        logic done;
        done       = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = l;
        for (int n = 0; n < 50 && !done; n++) begin
            tick();
            done = pushed;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL push_wait: got no accept for 0x%0h, expected accept within 50 cycles", d);
        end
        in_valid_i = 1'b0;
    endtask

    task automatic wait_req(input logic val, input int budget, input string name);
        int n;
        n = 0;
        while (req_o !== val && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(req_o), 32'(val));
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int   any_bad;
        int   n;
        int   pops_before;
        logic [3:0] exp_o;
        logic [3:0] act_o;

        // in_valid, data, last, gnt, out_ready | req, in_ready, out_valid, out_last
        vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        gnt_i       = 1'b0;
        out_ready_i = 1'b1;

        // reset state
        @(negedge clk_i);
        chk("rst_req", 32'(req_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // 3-word packet, grant, stream out, release
        for (int i = 0; i < 10; i++) begin
            in_valid_i  = vecs[i].in_valid;
            in_data_i   = vecs[i].in_data;
            in_last_i   = vecs[i].in_last;
            gnt_i       = vecs[i].gnt;
            out_ready_i = vecs[i].out_ready;
            @(negedge clk_i);
            exp_o = {vecs[i].exp_req, vecs[i].exp_in_ready, vecs[i].exp_out_valid,
                     vecs[i].exp_out_last};
            act_o = {req_o, in_ready_o, out_valid_o, out_valid_o & out_last_o};
            chk($sformatf("vec%0d", i), 32'(act_o), 32'(exp_o));
            monitor();
            @(posedge clk_i);
            #1;
        end
        chk("vec_sb_empty", sb.size(), 0);

        // two 2-word packets back to back under a held grant
        gnt_i = 1'b0;
        push_word(8'hA1, 1'b0);
        push_word(8'hA2, 1'b1);
        push_word(8'hB1, 1'b0);
        push_word(8'hB2, 1'b1);
        chk("two_pkt_full", 32'(in_ready_o), 32'd0);
        gnt_i = 1'b1;
        n = 0;
        popped_last = 1'b0;
        while (!popped_last && n < 20) begin
            tick();
            n++;
        end
        chk("pkt1_last_seen", 32'(popped_last), 32'd1);
        chk("rel_req_low", 32'(req_o), 32'd0);
        chk("rel_no_valid", 32'(out_valid_o), 32'd0);
        wait_req(1'b1, 3, "pkt2_rerequest");
        drain(20, "pkt2_drain");
        wait_req(1'b0, 3, "pkt2_release");

        // 6-word packet larger than the FIFO: cut-through request
        gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(8'hC0 + 8'(i), 1'b0);
        end
        chk("cut_full", 32'(in_ready_o), 32'd0);
        wait_req(1'b1, 3, "cut_req");
        gnt_i = 1'b1;
        push_word(8'hC4, 1'b0);
        push_word(8'hC5, 1'b1);
        gnt_i = 1'b0;
        drain(20, "cut_drain");
        wait_req(1'b0, 3, "cut_release");
        chk("cut_ready_back", 32'(in_ready_o), 32'd1);

        // downstream backpressure toggling, grant dropped mid-packet
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(8'hD0 + 8'(i), (i == 3) ? 1'b1 : 1'b0);
        end
        wait_req(1'b1, 4, "bp_req");
        gnt_i = 1'b1;
        tick();
        gnt_i = 1'b0;
        tick();
        chk("gnt_drop_hold", 32'(req_o), 32'd1);
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            out_ready_i = k[0];
            tick();
        end
        chk("bp_drain", sb.size(), 0);
        out_ready_i = 1'b1;
        wait_req(1'b0, 3, "bp_release");

`ifdef ARB_REQ_TIMEOUT_EN
        // grant withheld: timeout after TMO request cycles, then re-request
        gnt_i = 1'b0;
        push_word(8'hE5, 1'b1);
        wait_req(1'b1, 4, "tmo_req");
        n = 0;
        any_bad = 0;
        while (req_o && n < 20) begin
            if (timeout_o) any_bad++;
            tick();
            n++;
        end
        chk("tmo_req_cycles", 32'(n), 32'(TMO));
        chk("tmo_early_pulse", 32'(any_bad), 32'd0);
        chk("tmo_pulse", 32'(timeout_o), 32'd1);
        chk("tmo_req_drop", 32'(req_o), 32'd0);
        tick();
        chk("tmo_pulse_width", 32'(timeout_o), 32'd0);
        wait_req(1'b1, 4, "tmo_rerequest");
        gnt_i = 1'b1;
        drain(10, "tmo_drain");
        gnt_i = 1'b0;
        wait_req(1'b0, 3, "tmo_release");
`else
        // grant withheld: no timeout exists, request simply holds
        gnt_i = 1'b0;
        push_word(8'hE5, 1'b1);
        wait_req(1'b1, 4, "hold_req");
        any_bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (timeout_o || !req_o) any_bad++;
            tick();
        end
        chk("no_timeout", 32'(any_bad), 32'd0);
        gnt_i = 1'b1;
        drain(10, "hold_drain");
        gnt_i = 1'b0;
        wait_req(1'b0, 3, "hold_release");
`endif

        // asynchronous reset in the middle of a transfer
        for (int i = 0; i < 4; i++) begin
            push_word(8'hF0 + 8'(i), (i == 3) ? 1'b1 : 1'b0);
        end
        wait_req(1'b1, 4, "rst_seq_req");
        gnt_i = 1'b1;
        tick();
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_req", 32'(req_o), 32'd0);
        chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
        chk("midrst_in_ready", 32'(in_ready_o), 32'd1);
        chk("midrst_timeout", 32'(timeout_o), 32'd0);
        sb.delete();
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        pops_before = pops;
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        chk("no_stale_words", 32'(pops - pops_before), 32'd0);
        chk("post_rst_idle", 32'(req_o), 32'd0);
        push_word(8'h5A, 1'b1);
        drain(10, "post_rst_drain");
        chk("post_rst_pop_count", 32'(pops - pops_before), 32'd1);
        gnt_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
